// File: rtl/ifid_hold_ctrl.sv
// IF/ID stage controller: ID register, one-entry skid buffer and PC hold back to fetch.
// Optional stall/bubble performance counters are enabled by defining IFID_PERF_CNT_EN.
module ifid_hold_ctrl #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] fetch_inst,
  input  logic [DATA_W-1:0] fetch_pc2,
  input  logic              fetch_valid,
  input  logic              sendNOP,
  input  logic              mem_stall,
  input  logic              flush,
  output logic [DATA_W-1:0] id_inst,
  output logic [DATA_W-1:0] id_pc2,
  output logic              id_nop_n,
  output logic              pc_hold
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       bubble_cnt
`endif
);

  localparam logic [DATA_W-1:0] NOP_INST = DATA_W'(16'h0800);

  typedef enum logic [1:0] {S_EMPTY, S_FULL, S_SKID} state_t;

  state_t            state;
  logic [DATA_W-1:0] skid_inst_p0;
  logic [DATA_W-1:0] skid_pc2_p0;
  logic              skid_vld_p0;
  logic [DATA_W-1:0] id_inst_p1;
  logic [DATA_W-1:0] id_pc2_p1;
  logic              vld_p1;
  logic              go;

  assign go = sendNOP & ~mem_stall;

  // Skid (p0) -> ID register (p1); a bubble keeps the previous pc2
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_EMPTY;
      id_inst_p1  <= NOP_INST;
      id_pc2_p1   <= '0;
      vld_p1      <= 1'b0;
      skid_vld_p0 <= 1'b0;
    end else if (mem_stall) begin
      // EX is frozen as well, so a pending flush is honoured once the stall drops
    end else if (flush) begin
      state       <= S_EMPTY;
      id_inst_p1  <= NOP_INST;
      vld_p1      <= 1'b0;
      skid_vld_p0 <= 1'b0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (fetch_valid) begin
            id_inst_p1 <= fetch_inst;
            id_pc2_p1  <= fetch_pc2;
            vld_p1     <= 1'b1;
            state      <= S_FULL;
          end
        end
        S_FULL: begin
          if (go) begin
            if (fetch_valid) begin
              id_inst_p1 <= fetch_inst;
              id_pc2_p1  <= fetch_pc2;
            end else begin
              id_inst_p1 <= NOP_INST;
              vld_p1     <= 1'b0;
              state      <= S_EMPTY;
            end
          end else if (fetch_valid) begin
            skid_inst_p0 <= fetch_inst;
            skid_pc2_p0  <= fetch_pc2;
            skid_vld_p0  <= 1'b1;
            state        <= S_SKID;
          end
        end
        S_SKID: begin
          if (go) begin
            id_inst_p1  <= skid_inst_p0;
            id_pc2_p1   <= skid_pc2_p0;
            skid_vld_p0 <= 1'b0;
            state       <= S_FULL;
          end
        end
        default: begin
          state       <= S_EMPTY;
          id_inst_p1  <= NOP_INST;
          vld_p1      <= 1'b0;
          skid_vld_p0 <= 1'b0;
        end
      endcase
    end
  end

  assign id_inst  = id_inst_p1;
  assign id_pc2   = id_pc2_p1;
  assign id_nop_n = vld_p1;
  assign pc_hold  = skid_vld_p0;

`ifdef IFID_PERF_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic bubble_load;

  // A drained skid never yields a bubble, so only an empty skid can starve ID
  assign bubble_load = ~mem_stall & (flush | (go & ~fetch_valid & ~skid_vld_p0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (~go & vld_p1) stall_cnt <= sat_inc(stall_cnt);
      if (bubble_load)  bubble_cnt <= sat_inc(bubble_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_ifid_hold_ctrl.sv
// Bench for ifid_hold_ctrl: directed vector table followed by randomized traffic
// checked against a queue-based model of the in-order instruction stream.
module tb_ifid_hold_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] fetch_inst;
  logic [15:0] fetch_pc2;
  logic        fetch_valid;
  logic        sendNOP;
  logic        mem_stall;
  logic        flush;
  logic [15:0] id_inst;
  logic [15:0] id_pc2;
  logic        id_nop_n;
  logic        pc_hold;
`ifdef IFID_PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] bubble_cnt;
`endif

  ifid_hold_ctrl dut (
    .clk(clk), .rst_n(rst_n), .fetch_inst(fetch_inst), .fetch_pc2(fetch_pc2),
    .fetch_valid(fetch_valid), .sendNOP(sendNOP), .mem_stall(mem_stall), .flush(flush),
    .id_inst(id_inst), .id_pc2(id_pc2), .id_nop_n(id_nop_n), .pc_hold(pc_hold)
`ifdef IFID_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, fv, sn, ms, fl;
    logic [15:0] finst, fpc2;
    logic [15:0] e_inst, e_pc2;
    logic        e_nop_n, e_hold;
    logic [15:0] e_stall, e_bub;
  } vec_t;

  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] pc2;
  } ent_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nerr = 0;

  // Reference: pend[0] is the instruction in decode, pend[1] the one parked behind it
  ent_t        pend[$];
  logic [15:0] m_pc2;
`ifdef IFID_PERF_CNT_EN
  logic [15:0] m_stall, m_bub;
`endif

  function automatic logic [15:0] sat(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  task automatic v(input logic r, fv, sn, ms, fl, input logic [15:0] fi, fp,
                   input logic [15:0] ei, ep, input logic en, eh, input logic [15:0] es, eb);
    vec_t t;
    t = '{r, fv, sn, ms, fl, fi, fp, ei, ep, en, eh, es, eb};
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s vec %0d: got %h expected %h", name, nvec, act, exp);
    end
  endtask

  task automatic apply(input logic r, fv, sn, ms, fl, input logic [15:0] fi, fp);
    @(negedge clk);
    rst_n = r; fetch_valid = fv; sendNOP = sn; mem_stall = ms; flush = fl;
    fetch_inst = fi; fetch_pc2 = fp;
    @(posedge clk);
    #1;
    nvec++;
  endtask

  task automatic model_step(input logic r, fv, sn, ms, fl, input logic [15:0] fi, fp);
    bit go;
    go = sn && !ms;
    if (!r) begin
      pend.delete();
      m_pc2 = 16'h0000;
`ifdef IFID_PERF_CNT_EN
      m_stall = 0; m_bub = 0;
`endif
      return;
    end
`ifdef IFID_PERF_CNT_EN
    if (!go && pend.size() > 0) m_stall = sat(m_stall);
`endif
    if (ms) return;
    if (fl) begin
      pend.delete();
`ifdef IFID_PERF_CNT_EN
      m_bub = sat(m_bub);
`endif
    end else if (go) begin
      if (pend.size() > 0) void'(pend.pop_front());
      if (pend.size() == 0) begin
        if (fv) pend.push_back('{fi, fp});
`ifdef IFID_PERF_CNT_EN
        else m_bub = sat(m_bub);
`endif
      end
    end else if (pend.size() < 2 && fv) begin
      pend.push_back('{fi, fp});
    end
    if (pend.size() > 0) m_pc2 = pend[0].pc2;
  endtask

  initial begin
    rst_n = 1'b0; fetch_valid = 1'b0; sendNOP = 1'b1; mem_stall = 1'b0; flush = 1'b0;
    fetch_inst = '0; fetch_pc2 = '0;

    //  rst fv sn ms fl  finst     fpc2     | inst      pc2       nop  hold stall  bubble
    v(0, 1, 1, 0, 0, 16'h1111, 16'h0002,  16'h0800, 16'h0000, 0, 0, 16'd0, 16'd0);
    v(0, 1, 1, 0, 0, 16'h1111, 16'h0002,  16'h0800, 16'h0000, 0, 0, 16'd0, 16'd0);
    v(1, 1, 1, 0, 0, 16'h4001, 16'h0102,  16'h4001, 16'h0102, 1, 0, 16'd0, 16'd0);
    v(1, 1, 1, 0, 0, 16'h4002, 16'h0104,  16'h4002, 16'h0104, 1, 0, 16'd0, 16'd0);
    v(1, 1, 1, 0, 0, 16'h4003, 16'h0106,  16'h4003, 16'h0106, 1, 0, 16'd0, 16'd0);
    v(1, 1, 1, 0, 0, 16'h4001, 16'h0202,  16'h4001, 16'h0202, 1, 0, 16'd0, 16'd0);
    v(1, 1, 0, 0, 0, 16'h4002, 16'h0204,  16'h4001, 16'h0202, 1, 1, 16'd1, 16'd0);
    v(1, 1, 0, 0, 0, 16'h4002, 16'h0204,  16'h4001, 16'h0202, 1, 1, 16'd2, 16'd0);
    v(1, 1, 0, 0, 0, 16'h4002, 16'h0204,  16'h4001, 16'h0202, 1, 1, 16'd3, 16'd0);
    v(1, 1, 1, 0, 0, 16'h4002, 16'h0204,  16'h4002, 16'h0204, 1, 0, 16'd3, 16'd0);
    v(1, 1, 1, 0, 0, 16'h4003, 16'h0206,  16'h4003, 16'h0206, 1, 0, 16'd3, 16'd0);
    v(1, 1, 1, 0, 0, 16'hA000, 16'h0302,  16'hA000, 16'h0302, 1, 0, 16'd3, 16'd0);
    v(1, 1, 0, 0, 0, 16'hA002, 16'h0304,  16'hA000, 16'h0302, 1, 1, 16'd4, 16'd0);
    v(1, 1, 1, 0, 1, 16'hA004, 16'h0306,  16'h0800, 16'h0302, 0, 0, 16'd4, 16'd1);
    v(1, 1, 1, 0, 0, 16'hB000, 16'h0402,  16'hB000, 16'h0402, 1, 0, 16'd4, 16'd1);
    v(1, 1, 0, 0, 0, 16'hB002, 16'h0404,  16'hB000, 16'h0402, 1, 1, 16'd5, 16'd1);
    v(1, 1, 1, 1, 1, 16'hB004, 16'h0406,  16'hB000, 16'h0402, 1, 1, 16'd6, 16'd1);
    v(1, 1, 1, 1, 1, 16'hB004, 16'h0406,  16'hB000, 16'h0402, 1, 1, 16'd7, 16'd1);
    v(1, 1, 1, 0, 1, 16'hB004, 16'h0406,  16'h0800, 16'h0402, 0, 0, 16'd7, 16'd2);
    v(1, 1, 1, 0, 0, 16'hC000, 16'h0502,  16'hC000, 16'h0502, 1, 0, 16'd7, 16'd2);
    v(1, 0, 1, 0, 0, 16'hC002, 16'h0504,  16'h0800, 16'h0502, 0, 0, 16'd7, 16'd3);
    v(1, 0, 1, 0, 0, 16'hC002, 16'h0504,  16'h0800, 16'h0502, 0, 0, 16'd7, 16'd4);
    v(1, 0, 1, 0, 0, 16'hC002, 16'h0504,  16'h0800, 16'h0502, 0, 0, 16'd7, 16'd5);
    v(1, 0, 1, 0, 0, 16'hC002, 16'h0504,  16'h0800, 16'h0502, 0, 0, 16'd7, 16'd6);
    v(1, 1, 0, 0, 0, 16'hD000, 16'h0602,  16'hD000, 16'h0602, 1, 0, 16'd7, 16'd6);
    v(1, 0, 0, 0, 0, 16'hD001, 16'h0603,  16'hD000, 16'h0602, 1, 0, 16'd8, 16'd6);
    v(1, 1, 0, 0, 0, 16'hD002, 16'h0604,  16'hD000, 16'h0602, 1, 1, 16'd9, 16'd6);
    v(0, 1, 0, 0, 0, 16'hD004, 16'h0606,  16'h0800, 16'h0000, 0, 0, 16'd0, 16'd0);
    v(1, 0, 0, 0, 0, 16'hD004, 16'h0606,  16'h0800, 16'h0000, 0, 0, 16'd0, 16'd0);
    v(1, 0, 1, 0, 0, 16'hD004, 16'h0606,  16'h0800, 16'h0000, 0, 0, 16'd0, 16'd1);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst_n, tbl[i].fv, tbl[i].sn, tbl[i].ms, tbl[i].fl, tbl[i].finst, tbl[i].fpc2);
      chk("id_inst", id_inst, tbl[i].e_inst);
      chk("id_pc2", id_pc2, tbl[i].e_pc2);
      chk("id_nop_n", {15'd0, id_nop_n}, {15'd0, tbl[i].e_nop_n});
      chk("pc_hold", {15'd0, pc_hold}, {15'd0, tbl[i].e_hold});
`ifdef IFID_PERF_CNT_EN
      chk("stall_cnt", stall_cnt, tbl[i].e_stall);
      chk("bubble_cnt", bubble_cnt, tbl[i].e_bub);
`endif
    end

    // Randomized traffic against the stream model, starting from reset
    for (int i = 0; i < 3000; i++) begin
      logic r, fv, sn, ms, fl;
      logic [15:0] fi, fp;
      r  = (i == 0) ? 1'b0 : ($urandom_range(0, 63) != 0);
      fv = ($urandom_range(0, 3) != 0);
      sn = ($urandom_range(0, 9) < 6);
      ms = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 7) == 0);
      fi = 16'($urandom);
      fp = 16'($urandom);
      apply(r, fv, sn, ms, fl, fi, fp);
      model_step(r, fv, sn, ms, fl, fi, fp);
      chk("rnd_id_inst", id_inst, (pend.size() > 0) ? pend[0].inst : 16'h0800);
      chk("rnd_id_pc2", id_pc2, m_pc2);
      chk("rnd_id_nop_n", {15'd0, id_nop_n}, {15'd0, pend.size() > 0});
      chk("rnd_pc_hold", {15'd0, pc_hold}, {15'd0, pend.size() == 2});
`ifdef IFID_PERF_CNT_EN
      chk("rnd_stall_cnt", stall_cnt, m_stall);
      chk("rnd_bubble_cnt", bubble_cnt, m_bub);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ifid_hold_ctrl.md
# ifid_hold_ctrl

IF/ID pipeline stage controller: the consumer of the decode-stage hazard stall request (`sendNOP`, active-low) and the fetch/memory cache stalls. It owns the IF/ID instruction and PC+2 registers, a one-entry skid buffer and the PC hold signal back to fetch. It keeps decode frozen while a hazard is pending, never loses or duplicates a fetched instruction, and injects NOP bubbles (16'h0800) on flush and fetch miss.

## Interface
- `NOP_INST`, 16'h0800, encoding loaded into the ID register for a bubble.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `fetch_inst`  in  16  instruction from instruction memory/cache.
- `fetch_pc2`  in  16  PC+2 of `fetch_inst`.
- `fetch_valid`  in  1  `fetch_inst`/`fetch_pc2` valid this cycle (low during I-cache stall).
- `sendNOP`  in  1  low = decode must hold (hazard); high = decode may advance.
- `mem_stall`  in  1  D-cache stall; freezes this stage completely.
- `flush`  in  1  taken branch/jump resolved in EX; squash ID and skid.
- `id_inst`  out  16  instruction presented to decode.
- `id_pc2`  out  16  PC+2 presented to decode.
- `id_nop_n`  out  1  low when `id_inst` is a bubble (matches the NOPEx/NOPMem/NOPWB polarity).
- `pc_hold`  out  1  high = fetch must not advance PC; `fetch_valid` is ignored.
- `stall_cnt`, `bubble_cnt`  out  16 each  present only with `IFID_PERF_CNT_EN`.

## Operation
- `go = sendNOP & ~mem_stall`. State: ID register (inst, pc2, valid) plus skid (inst, pc2, valid). FSM states derived: EMPTY (ID bubble, skid empty), FULL (ID valid, skid empty), SKID (ID valid, skid valid). Skid valid with ID bubble is unreachable.
- Priority per edge, highest first:
  1. `~rst_n`: ID <= `NOP_INST`, pc2 <= 0, `id_nop_n` <= 0, skid cleared, counters <= 0 → EMPTY.
  2. `mem_stall`: every register holds, flush included. EX is frozen too, so `flush` stays asserted until `mem_stall` drops.
  3. `flush`: ID <= bubble, skid cleared → EMPTY. `fetch_valid` is dropped that cycle.
  4. `go`: ID <= skid if skid valid (skid cleared). Else ID <= fetch if `fetch_valid`. Else ID <= bubble.
  5. `~go` (hazard hold): ID holds. If skid empty and `fetch_valid`, skid <= fetch → SKID. If skid full, nothing is captured.
- In EMPTY, `sendNOP` low has no effect: nothing is pending. Fetch goes to skid only when ID is valid. With ID a bubble it loads straight into ID, even with `go` low.
- `pc_hold = skid_valid` (registered; no combinational path from any input).
- ID bubble: inst = `NOP_INST`, pc2 holds its previous value, `id_nop_n` = 0.

## Timing
- Fetch→decode latency: 1 cycle (instruction on `fetch_inst` at edge N is on `id_inst` after edge N).
- Skid path latency: 1 extra cycle per hold; order is strictly preserved: ID, then skid, then new fetch.
- `pc_hold` rises the cycle after a capture into skid. It falls the cycle after the skid drains. While `pc_hold` is high, fetch re-presents the same PC, and that data is ignored.
- Hold with simultaneous `go` low and `flush` high: flush wins.
- Reset mid-hold: all state discarded next edge, `pc_hold` = 0.

## Configuration
- `IFID_PERF_CNT_EN` defined: `stall_cnt` increments every non-reset cycle with `~go` and ID valid. `bubble_cnt` increments every cycle ID is loaded with a bubble, from flush or from `go` with no fetch. Both counters saturate at 16'hFFFF and clear on reset.
- Undefined: both ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset: hold `rst_n` = 0 two cycles with `fetch_valid` = 1 → `id_inst` = 16'h0800, `id_nop_n` = 0, `pc_hold` = 0, counters 0.
- Streaming: `sendNOP` = 1, fetch 16'h4001/16'h4002/16'h4003 on consecutive cycles → each appears on `id_inst` one cycle later, `pc_hold` stays 0.
- Hazard hold: ID = 16'h4001, `sendNOP` = 0 for 3 cycles while fetch offers 16'h4002 → ID stays 16'h4001, skid takes 16'h4002, `pc_hold` = 1 from cycle 2. On `sendNOP` = 1, ID = 16'h4002, then the next fetch follows, with no loss or duplicate.
- Flush during SKID: ID = 16'hA000, skid valid, `flush` = 1 → next cycle `id_inst` = 16'h0800, `id_nop_n` = 0, `pc_hold` = 0; with counters, `bubble_cnt` +1.
- `mem_stall` + `flush`: both high 2 cycles → ID/skid unchanged; `mem_stall` drops with `flush` still high → squash on that edge.
- I-cache miss: `go` = 1, `fetch_valid` = 0 for 4 cycles → 4 bubbles (`bubble_cnt` = 4 with macro); `stall_cnt` counts only `~go` cycles with valid ID.
